// File: rtl/run_detector_moore.sv
// rtl/run_detector_moore.sv - Moore detector for RUN_LEN consecutive valid samples equal to target.
// Optional macro DETECT_COUNT_EN adds cnt_clr input and a saturating det_count output.
module run_detector_moore #(
  parameter int RUN_LEN = 3,
  parameter int DCNT_W  = 16,
  localparam int CNT_W  = $clog2(RUN_LEN + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             data_in,
  input  logic             valid_in,
  input  logic             target,
  input  logic             overlap,
  output logic             detect,
  output logic [CNT_W-1:0] run_cnt,
  output logic             in_run
`ifdef DETECT_COUNT_EN
  ,
  input  logic              cnt_clr,
  output logic [DCNT_W-1:0] det_count
`endif
);

  if (RUN_LEN < 2) begin : g_bad_run_len
    $error("run_detector_moore: RUN_LEN must be >= 2");
  end
  if (DCNT_W < 1) begin : g_bad_dcnt_w
    $error("run_detector_moore: DCNT_W must be >= 1");
  end

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    COUNT = 2'b01,
    MATCH = 2'b10
  } state_t;

  localparam logic [CNT_W-1:0] RUN_MAX = CNT_W'(RUN_LEN);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             det_q, det_d;
  logic             in_run_q;
  logic             is_match, is_miss;
  logic [CNT_W-1:0] cnt_inc;

  assign is_match = valid_in && (data_in == target);
  assign is_miss  = valid_in && (data_in != target);
  assign cnt_inc  = cnt_q + CNT_W'(1);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      det_q    <= 1'b0;
      in_run_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      det_q    <= det_d;
      in_run_q <= (state_d == MATCH);
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    det_d   = 1'b0;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (is_match) begin
          state_d = COUNT;
          cnt_d   = CNT_W'(1);
        end
      end
      COUNT: begin
        if (is_miss) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (is_match) begin
          if (cnt_inc == RUN_MAX) begin
            det_d = 1'b1;
            if (overlap) begin
              state_d = MATCH;
              cnt_d   = RUN_MAX;
            end else begin
              state_d = IDLE;
              cnt_d   = '0;
            end
          end else begin
            cnt_d = cnt_inc;
          end
        end
      end
      MATCH: begin
        if (is_miss) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (is_match) begin
          det_d = 1'b1;
          // Non-overlap mode restarts after this hit instead of staying saturated
          if (!overlap) begin
            state_d = IDLE;
            cnt_d   = '0;
          end
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  assign detect  = det_q;
  assign run_cnt = cnt_q;
  assign in_run  = in_run_q;

`ifdef DETECT_COUNT_EN
  logic [DCNT_W-1:0] dcnt_q, dcnt_d;

  always_comb begin
    dcnt_d = dcnt_q;
    if (cnt_clr) begin
      dcnt_d = '0;
    end else if (det_d && (dcnt_q != {DCNT_W{1'b1}})) begin
      dcnt_d = dcnt_q + DCNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      dcnt_q <= '0;
    end else begin
      dcnt_q <= dcnt_d;
    end
  end

  assign det_count = dcnt_q;
`endif

endmodule

// File: tb/tb_run_detector_moore.sv
// tb/tb_run_detector_moore.sv - directed self-checking bench for run_detector_moore (RUN_LEN=3).
module tb_run_detector_moore;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       data_in = 1'b0;
  logic       valid_in = 1'b0;
  logic       target = 1'b1;
  logic       overlap = 1'b1;
  logic       detect;
  logic [1:0] run_cnt;
  logic       in_run;
`ifdef DETECT_COUNT_EN
  logic       cnt_clr = 1'b0;
  logic [1:0] det_count;
`endif

  int pass_cnt = 0;
  int total_cnt = 0;

  always #5 clk = ~clk;

  run_detector_moore #(.RUN_LEN(3), .DCNT_W(2)) dut (
    .clk      (clk),
    .reset    (reset),
    .data_in  (data_in),
    .valid_in (valid_in),
    .target   (target),
    .overlap  (overlap),
    .detect   (detect),
    .run_cnt  (run_cnt),
    .in_run   (in_run)
`ifdef DETECT_COUNT_EN
    ,
    .cnt_clr  (cnt_clr),
    .det_count(det_count)
`endif
  );

  task automatic do_reset();
    @(negedge clk);
    valid_in = 1'b0;
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
  endtask

  // Drive one sample at the falling edge, then observe 1 time unit after the rising edge.
  task automatic step(input logic d, input logic v);
    @(negedge clk);
    data_in  = d;
    valid_in = v;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    #3;
    total_cnt++;
    if ({detect, run_cnt, in_run} !== 4'b0000)
      $display("FAIL reset_outputs: got det=%b cnt=%0d in_run=%b want 0/0/0", detect, run_cnt, in_run);
    else pass_cnt++;
`ifdef DETECT_COUNT_EN
    total_cnt++;
    if (det_count !== 2'd0) $display("FAIL reset_det_count: got %0d want 0", det_count);
    else pass_cnt++;
`endif
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic test_overlap();
    logic       dv [5] = '{1, 1, 1, 1, 0};
    logic [1:0] ec [5] = '{1, 2, 3, 3, 0};
    logic       ed [5] = '{0, 0, 1, 1, 0};
    logic       er [5] = '{0, 0, 1, 1, 0};
    do_reset();
    target = 1'b1; overlap = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step(dv[i], 1'b1);
      total_cnt++;
      if ({run_cnt, detect, in_run} !== {ec[i], ed[i], er[i]})
        $display("FAIL overlap[%0d]: got cnt=%0d det=%b in_run=%b want cnt=%0d det=%b in_run=%b",
                 i, run_cnt, detect, in_run, ec[i], ed[i], er[i]);
      else pass_cnt++;
    end
  endtask

  task automatic test_non_overlap();
    logic [1:0] ec [6] = '{1, 2, 0, 1, 2, 0};
    logic       ed [6] = '{0, 0, 1, 0, 0, 1};
    do_reset();
    target = 1'b1; overlap = 1'b0;
    for (int i = 0; i < 6; i++) begin
      step(1'b1, 1'b1);
      total_cnt++;
      if ({run_cnt, detect, in_run} !== {ec[i], ed[i], 1'b0})
        $display("FAIL non_overlap[%0d]: got cnt=%0d det=%b in_run=%b want cnt=%0d det=%b in_run=0",
                 i, run_cnt, detect, in_run, ec[i], ed[i]);
      else pass_cnt++;
    end
  endtask

  task automatic test_bubble();
    logic       vv [6] = '{1, 0, 0, 1, 1, 0};
    logic [1:0] ec [6] = '{1, 1, 1, 2, 3, 3};
    logic       ed [6] = '{0, 0, 0, 0, 1, 0};
    logic       er [6] = '{0, 0, 0, 0, 1, 1};
    do_reset();
    target = 1'b1; overlap = 1'b1;
    for (int i = 0; i < 6; i++) begin
      step(vv[i] ? 1'b1 : 1'b0, vv[i]);
      total_cnt++;
      if ({run_cnt, detect, in_run} !== {ec[i], ed[i], er[i]})
        $display("FAIL bubble[%0d]: got cnt=%0d det=%b in_run=%b want cnt=%0d det=%b in_run=%b",
                 i, run_cnt, detect, in_run, ec[i], ed[i], er[i]);
      else pass_cnt++;
    end
  endtask

  task automatic test_target_zero();
    logic       dv [6] = '{0, 0, 1, 0, 0, 0};
    logic [1:0] ec [6] = '{1, 2, 0, 1, 2, 3};
    logic       ed [6] = '{0, 0, 0, 0, 0, 1};
    do_reset();
    target = 1'b0; overlap = 1'b1;
    for (int i = 0; i < 6; i++) begin
      step(dv[i], 1'b1);
      total_cnt++;
      if ({run_cnt, detect} !== {ec[i], ed[i]})
        $display("FAIL target_zero[%0d]: got cnt=%0d det=%b want cnt=%0d det=%b",
                 i, run_cnt, detect, ec[i], ed[i]);
      else pass_cnt++;
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    target = 1'b1; overlap = 1'b1;
    step(1'b1, 1'b1);
    step(1'b1, 1'b1);
    total_cnt++;
    if (run_cnt !== 2'd2) $display("FAIL async_pre: got cnt=%0d want 2", run_cnt);
    else pass_cnt++;
    @(negedge clk);
    valid_in = 1'b0;
    #2 reset = 1'b0;
    #1;
    total_cnt++;
    if ({detect, run_cnt, in_run} !== 4'b0000)
      $display("FAIL async_mid: got det=%b cnt=%0d in_run=%b want 0/0/0", detect, run_cnt, in_run);
    else pass_cnt++;
    #1 reset = 1'b1;
    step(1'b1, 1'b1);
    step(1'b1, 1'b1);
    total_cnt++;
    if ({run_cnt, detect} !== {2'd2, 1'b0})
      $display("FAIL async_after2: got cnt=%0d det=%b want cnt=2 det=0", run_cnt, detect);
    else pass_cnt++;
    step(1'b1, 1'b1);
    total_cnt++;
    if ({run_cnt, detect} !== {2'd3, 1'b1})
      $display("FAIL async_after3: got cnt=%0d det=%b want cnt=3 det=1", run_cnt, detect);
    else pass_cnt++;
  endtask

  task automatic test_overlap_switch();
    do_reset();
    target = 1'b1; overlap = 1'b1;
    step(1'b1, 1'b1);
    step(1'b1, 1'b1);
    step(1'b1, 1'b1);
    overlap = 1'b0;
    step(1'b1, 1'b1);
    total_cnt++;
    if ({run_cnt, detect, in_run} !== {2'd0, 1'b1, 1'b0})
      $display("FAIL overlap_switch: got cnt=%0d det=%b in_run=%b want cnt=0 det=1 in_run=0",
               run_cnt, detect, in_run);
    else pass_cnt++;
    step(1'b1, 1'b1);
    total_cnt++;
    if ({run_cnt, detect} !== {2'd1, 1'b0})
      $display("FAIL overlap_switch_next: got cnt=%0d det=%b want cnt=1 det=0", run_cnt, detect);
    else pass_cnt++;
  endtask

  task automatic test_target_change();
    do_reset();
    target = 1'b1; overlap = 1'b1;
    step(1'b1, 1'b1);
    step(1'b1, 1'b1);
    target = 1'b0;
    step(1'b0, 1'b1);
    total_cnt++;
    if ({run_cnt, detect, in_run} !== {2'd3, 1'b1, 1'b1})
      $display("FAIL target_change: got cnt=%0d det=%b in_run=%b want cnt=3 det=1 in_run=1",
               run_cnt, detect, in_run);
    else pass_cnt++;
    step(1'b1, 1'b1);
    total_cnt++;
    if ({run_cnt, detect, in_run} !== {2'd0, 1'b0, 1'b0})
      $display("FAIL target_change_miss: got cnt=%0d det=%b in_run=%b want 0/0/0",
               run_cnt, detect, in_run);
    else pass_cnt++;
  endtask

`ifdef DETECT_COUNT_EN
  task automatic test_det_count();
    logic [1:0] ek [6] = '{0, 0, 1, 2, 3, 3};
    do_reset();
    target = 1'b1; overlap = 1'b1; cnt_clr = 1'b0;
    for (int i = 0; i < 6; i++) begin
      step(1'b1, 1'b1);
      total_cnt++;
      if (det_count !== ek[i])
        $display("FAIL det_count[%0d]: got %0d want %0d", i, det_count, ek[i]);
      else pass_cnt++;
    end
    cnt_clr = 1'b1;
    step(1'b1, 1'b1);
    total_cnt++;
    if ({detect, det_count} !== {1'b1, 2'd0})
      $display("FAIL det_count_clr: got det=%b cnt=%0d want det=1 cnt=0", detect, det_count);
    else pass_cnt++;
    cnt_clr = 1'b0;
  endtask
`endif

  initial begin
    test_reset();
    test_overlap();
    test_non_overlap();
    test_bubble();
    test_target_zero();
    test_async_reset();
    test_overlap_switch();
    test_target_change();
`ifdef DETECT_COUNT_EN
    test_det_count();
`endif
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
